seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_glyph.sv | 19 +
 rtl/seg7_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width,
// the blank glyph and the 16-entry nibble-to-glyph table (ABCDEFG, A = MSB).
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] BLANK_GLYPH = '0;

  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'b1111110, // 0
    7'b0110000, // 1
    7'b1101101, // 2
    7'b1111001, // 3
    7'b0110011, // 4
    7'b1011011, // 5
    7'b1011111, // 6
    7'b1110000, // 7
    7'b1111111, // 8
    7'b1110011, // 9
    7'b1110111, // A
    7'b0011111, // b
    7'b1001110, // C
    7'b0111101, // d
    7'b1001111, // E
    7'b1000111  // F
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder (logical, active-high segments).
// With hex_mode low, nibbles 10..15 decode to the blank glyph.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] glyph
);

  // Table lookup, blanking the letter range when hex display is disabled
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
    if (!hex_mode && (nibble > 4'd9)) begin
      glyph = BLANK_GLYPH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. A slot counter divides each digit
// slot into a short all-off guard followed by the display portion; a digit
// index walks the digits. New values are captured into a shadow set on load
// and copied to the active set only at the frame boundary.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned HEX_MODE       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SHOW_FROM = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  // Pin levels that mean "off" for each output group
  localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]             slot_cnt;
  logic [DW-1:0]             dig_idx;
  logic                      commit;

  logic [4*NUM_DIGITS-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic                      shadow_lzb;
  logic                      pending;

  logic [4*NUM_DIGITS-1:0]   act_data;
  logic [NUM_DIGITS-1:0]     act_dp;
  logic                      act_lzb;

  logic [NUM_DIGITS-1:0]     lzb_mask;
  logic [3:0]                cur_nibble;
  logic                      cur_dp;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     cur_onehot;
  logic                      hex_en;
  logic [SEG_W-1:0]          raw_glyph;

  logic [SEG_W-1:0]          seg_nxt;
  logic                      dp_nxt;
  logic [NUM_DIGITS-1:0]     en_nxt;

  assign commit = (slot_cnt == SLOT_LAST) && (dig_idx == DIG_LAST);
  assign hex_en = (HEX_MODE != 0);

  // Slot counter and digit index; the index advances when the slot wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Shadow capture on load, shadow-to-active commit at the frame boundary.
  // A load landing on the commit edge bypasses the shadow straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_lzb  <= 1'b0;
      pending     <= 1'b0;
      act_data    <= '0;
      act_dp      <= '0;
      act_lzb     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp_in;
        shadow_lzb  <= lzb_en;
      end
      if (commit) begin
        if (load) begin
          act_data    <= data;
          act_dp      <= dp_in;
          act_lzb     <= lzb_en;
          pending     <= 1'b0;
          frame_start <= 1'b1;
        end else if (pending) begin
          act_data    <= shadow_data;
          act_dp      <= shadow_dp;
          act_lzb     <= shadow_lzb;
          pending     <= 1'b0;
          frame_start <= 1'b1;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: bit k set when nibbles NUM_DIGITS-1..k are all zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lzb_mask   = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (act_data[4*k +: 4] == 4'd0);
      lzb_mask[k] = zero_above;
    end
  end

  // Select nibble, dp, blanking and one-hot enable for the current digit
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx == DW'(k)) begin
        cur_nibble    = act_data[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_blank     = act_lzb && lzb_mask[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble   (cur_nibble),
    .hex_mode (hex_en),
    .glyph    (raw_glyph)
  );

  // Next pin levels: all off during the guard, current digit afterwards
  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = DP_OFF;
    en_nxt  = DIG_OFF;
    if (slot_cnt >= SHOW_FROM) begin
      seg_nxt = (cur_blank ? BLANK_GLYPH : raw_glyph) ^ SEG_OFF;
      dp_nxt  = cur_dp ^ DP_OFF;
      en_nxt  = cur_onehot ^ DIG_OFF;
    end
  end

  // Output registers hold pin levels directly, so reset drives them off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments <= SEG_OFF;
      dp       <= DP_OFF;
      digit_en <= DIG_OFF;
    end else begin
      segments <= seg_nxt;
      dp       <= dp_nxt;
      digit_en <= en_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, CLK_DIV=8,
// BLANK_CYCLES=2. Three instances share the inputs: hex mode, decimal mode,
// and active-low segments/digits.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        lzb_en;

  logic [6:0]  h_seg, d_seg, i_seg;
  logic        h_dp, d_dp, i_dp;
  logic [3:0]  h_en, d_en, i_en;
  logic        h_fs, d_fs, i_fs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -1;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .lzb_en(lzb_en), .segments(h_seg), .dp(h_dp), .digit_en(h_en),
    .frame_start(h_fs)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dec (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .lzb_en(lzb_en), .segments(d_seg), .dp(d_dp), .digit_en(d_en),
    .frame_start(d_fs)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_inv (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .lzb_en(lzb_en), .segments(i_seg), .dp(i_dp), .digit_en(i_en),
    .frame_start(i_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = index of the output cycle after the most recent rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    #22;
    n_cmp++; if (h_seg !== 7'h00) begin n_bad++; $display("FAIL reset_seg got=%b want=%b", h_seg, 7'h00); end
    n_cmp++; if (h_dp !== 1'b0) begin n_bad++; $display("FAIL reset_dp got=%b want=0", h_dp); end
    n_cmp++; if (h_en !== 4'h0) begin n_bad++; $display("FAIL reset_en got=%b want=0000", h_en); end
    n_cmp++; if (h_fs !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b want=0", h_fs); end
    n_cmp++; if (i_seg !== 7'h7F) begin n_bad++; $display("FAIL reset_inv_seg got=%b want=1111111", i_seg); end
    n_cmp++; if (i_dp !== 1'b1) begin n_bad++; $display("FAIL reset_inv_dp got=%b want=1", i_dp); end
    n_cmp++; if (i_en !== 4'hF) begin n_bad++; $display("FAIL reset_inv_en got=%b want=1111", i_en); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  task automatic test_timeline();
    logic [6:0] es;
    logic [3:0] ee;
    for (int c = 0; c < 16; c++) begin
      tick();
      if ((c % 8) < 2) begin
        es = 7'h00; ee = 4'h0;
      end else begin
        es = 7'h7E; ee = 4'b0001 << (c / 8);
      end
      n_cmp++; if (h_seg !== es) begin n_bad++; $display("FAIL timeline_seg cyc=%0d got=%b want=%b", cyc, h_seg, es); end
      n_cmp++; if (h_en !== ee) begin n_bad++; $display("FAIL timeline_en cyc=%0d got=%b want=%b", cyc, h_en, ee); end
      n_cmp++; if (h_dp !== 1'b0) begin n_bad++; $display("FAIL timeline_dp cyc=%0d got=%b want=0", cyc, h_dp); end
      if (c == 3) begin
        n_cmp++; if (i_seg !== 7'h01) begin n_bad++; $display("FAIL timeline_inv_seg got=%b want=0000001", i_seg); end
        n_cmp++; if (i_en !== 4'hE) begin n_bad++; $display("FAIL timeline_inv_en got=%b want=1110", i_en); end
      end
    end
  endtask

  task automatic test_hex_load();
    logic [6:0] es [4] = '{7'h7E, 7'h4E, 7'h5B, 7'h77};
    logic [6:0] e;
    goto(15);
    data = 16'hA5C0; dp_in = 4'b0100; lzb_en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    while (cyc < 30) begin
      tick();
      e = ((cyc % 8) < 2) ? 7'h00 : 7'h7E;
      n_cmp++; if (h_seg !== e) begin n_bad++; $display("FAIL hold_seg cyc=%0d got=%b want=%b", cyc, h_seg, e); end
      n_cmp++; if (h_fs !== 1'b0) begin n_bad++; $display("FAIL hold_fs cyc=%0d got=%b want=0", cyc, h_fs); end
    end
    goto(31);
    n_cmp++; if (h_fs !== 1'b1) begin n_bad++; $display("FAIL hex_fs got=%b want=1", h_fs); end
    n_cmp++; if (h_seg !== 7'h7E) begin n_bad++; $display("FAIL hex_tear got=%b want=1111110", h_seg); end
    for (int d = 0; d < 4; d++) begin
      goto(32 + 8*d + 4);
      n_cmp++; if (h_seg !== es[d]) begin n_bad++; $display("FAIL hex_seg d=%0d got=%b want=%b", d, h_seg, es[d]); end
      n_cmp++; if (h_dp !== (d == 2)) begin n_bad++; $display("FAIL hex_dp d=%0d got=%b want=%b", d, h_dp, (d == 2)); end
      n_cmp++; if (h_en !== (4'b0001 << d)) begin n_bad++; $display("FAIL hex_en d=%0d got=%b want=%b", d, h_en, 4'b0001 << d); end
    end
  endtask

  task automatic test_dec_lzb();
    logic [6:0] ed [4] = '{7'h70, 7'h00, 7'h00, 7'h00};
    logic [6:0] eh [4] = '{7'h70, 7'h47, 7'h00, 7'h00};
    goto(70);
    data = 16'h00F7; dp_in = 4'b0000; lzb_en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    goto(95);
    n_cmp++; if (d_fs !== 1'b1) begin n_bad++; $display("FAIL dec_fs got=%b want=1", d_fs); end
    for (int d = 0; d < 4; d++) begin
      goto(96 + 8*d + 4);
      n_cmp++; if (d_seg !== ed[d]) begin n_bad++; $display("FAIL dec_seg d=%0d got=%b want=%b", d, d_seg, ed[d]); end
      n_cmp++; if (d_en !== (4'b0001 << d)) begin n_bad++; $display("FAIL dec_en d=%0d got=%b want=%b", d, d_en, 4'b0001 << d); end
      n_cmp++; if (h_seg !== eh[d]) begin n_bad++; $display("FAIL lzb_hex_seg d=%0d got=%b want=%b", d, h_seg, eh[d]); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    goto(100);
    data = 16'h1111; lzb_en = 1'b0; load = 1'b1;
    tick(); if (h_fs) pulses++;
    load = 1'b0;
    while (cyc < 110) begin tick(); if (h_fs) pulses++; end
    data = 16'h2222; load = 1'b1;
    tick(); if (h_fs) pulses++;
    load = 1'b0;
    while (cyc < 165) begin
      tick(); if (h_fs) pulses++;
      if (cyc == 132 || cyc == 140 || cyc == 148 || cyc == 156 || cyc == 164) begin
        n_cmp++; if (h_seg !== 7'h6D) begin n_bad++; $display("FAIL b2b_seg cyc=%0d got=%b want=1101101", cyc, h_seg); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_commit_edge_load();
    logic [6:0] es [4] = '{7'h30, 7'h6D, 7'h33, 7'h7F};
    goto(190);
    data = 16'h8421; dp_in = 4'b0001; lzb_en = 1'b0; load = 1'b1;
    n_cmp++; if (h_fs !== 1'b0) begin n_bad++; $display("FAIL edge_fs_pre got=%b want=0", h_fs); end
    tick();
    load = 1'b0;
    n_cmp++; if (h_fs !== 1'b1) begin n_bad++; $display("FAIL edge_fs got=%b want=1", h_fs); end
    n_cmp++; if (h_seg !== 7'h6D) begin n_bad++; $display("FAIL edge_tear got=%b want=1101101", h_seg); end
    for (int d = 0; d < 4; d++) begin
      goto(192 + 8*d + 2);
      n_cmp++; if (h_seg !== es[d]) begin n_bad++; $display("FAIL edge_seg d=%0d got=%b want=%b", d, h_seg, es[d]); end
      n_cmp++; if (h_dp !== (d == 0)) begin n_bad++; $display("FAIL edge_dp d=%0d got=%b want=%b", d, h_dp, (d == 0)); end
    end
    goto(223);
    n_cmp++; if (h_fs !== 1'b0) begin n_bad++; $display("FAIL idle_commit_fs got=%b want=0", h_fs); end
  endtask

  task automatic test_reset_mid_slot();
    goto(228);
    n_cmp++; if (h_seg !== 7'h30) begin n_bad++; $display("FAIL pre_reset_seg got=%b want=0110000", h_seg); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (h_seg !== 7'h00) begin n_bad++; $display("FAIL async_seg got=%b want=0000000", h_seg); end
    n_cmp++; if (h_dp !== 1'b0) begin n_bad++; $display("FAIL async_dp got=%b want=0", h_dp); end
    n_cmp++; if (h_en !== 4'h0) begin n_bad++; $display("FAIL async_en got=%b want=0000", h_en); end
    n_cmp++; if (i_seg !== 7'h7F) begin n_bad++; $display("FAIL async_inv_seg got=%b want=1111111", i_seg); end
    n_cmp++; if (i_dp !== 1'b1) begin n_bad++; $display("FAIL async_inv_dp got=%b want=1", i_dp); end
    n_cmp++; if (i_en !== 4'hF) begin n_bad++; $display("FAIL async_inv_en got=%b want=1111", i_en); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
    tick();
    n_cmp++; if (i_seg !== 7'h7F) begin n_bad++; $display("FAIL rel_inv_seg got=%b want=1111111", i_seg); end
    n_cmp++; if (i_en !== 4'hF) begin n_bad++; $display("FAIL rel_inv_en got=%b want=1111", i_en); end
    goto(4);
    n_cmp++; if (h_seg !== 7'h7E) begin n_bad++; $display("FAIL rel_seg got=%b want=1111110", h_seg); end
    n_cmp++; if (h_en !== 4'h1) begin n_bad++; $display("FAIL rel_en got=%b want=0001", h_en); end
    n_cmp++; if (h_dp !== 1'b0) begin n_bad++; $display("FAIL rel_dp got=%b want=0", h_dp); end
    n_cmp++; if (i_seg !== 7'h01) begin n_bad++; $display("FAIL rel_inv_seg4 got=%b want=0000001", i_seg); end
    n_cmp++; if (i_dp !== 1'b1) begin n_bad++; $display("FAIL rel_inv_dp got=%b want=1", i_dp); end
    n_cmp++; if (i_en !== 4'hE) begin n_bad++; $display("FAIL rel_inv_en4 got=%b want=1110", i_en); end
    goto(12);
    n_cmp++; if (h_seg !== 7'h7E) begin n_bad++; $display("FAIL rel_d1_seg got=%b want=1111110", h_seg); end
    n_cmp++; if (h_en !== 4'h2) begin n_bad++; $display("FAIL rel_d1_en got=%b want=0010", h_en); end
  endtask

  initial begin
    rst_n  = 1'b1;
    load   = 1'b0;
    data   = '0;
    dp_in  = '0;
    lzb_en = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_timeline();
    test_hex_load();
    test_dec_lzb();
    test_back_to_back();
    test_commit_edge_load();
    test_reset_mid_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
